wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the single register-file write port between the ALU result path (backpressurable) and the LSU result path (not backpressurable).
- Buffers LSU results that lose arbitration in a small FIFO and round-robins between sources when both are pending.
- Drives a registered write port into the register file and produces a load-issue stall so the FIFO never overflows in normal operation.
- Sits between the execute/LSU stages and the register file, in place of a purely combinational result mux.

Parameters:
- LSU_FIFO_DEPTH, 4, entries in the LSU result FIFO; must be a power of two and >= 2.
- XLEN, from riscv_types, data width (package constant, not overridden per instance).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- alu_valid  input  1  ALU result available.
- alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
- alu_rd  input  rs_addr_t  ALU destination register.
- alu_data  input  XLEN  ALU result.
- lsu_valid  input  1  LSU result present; single-cycle pulse, cannot be stalled.
- lsu_rd  input  rs_addr_t  LSU destination register.
- lsu_data  input  XLEN  LSU result.
- lsu_stall  output  1  block issue of new loads.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  rs_addr_t  register-file write address.
- rf_wdata  output  XLEN  register-file write data.
- fifo_count  output  $clog2(LSU_FIFO_DEPTH)+1  current LSU FIFO occupancy.
- overflow  output  1  sticky error flag: an LSU result was dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, fifo_count=0, overflow=0, FIFO empty, last_grant=LSU.
- LSU candidate: the FIFO head when fifo_count>0. Otherwise the incoming lsu_valid beat (bypass path).
- ALU candidate: alu_valid.
- alu_ready = !L_present || (last_grant==LSU). L_present means fifo_count>0 || lsu_valid.
  - alu_ready does not depend on alu_valid.
- Grant rules:
  - Only one candidate present: it is granted.
  - Both present: grant the source not granted last (round-robin).
  - last_grant updates only on a cycle in which a grant occurs.
- LSU grant with FIFO non-empty:
  - Pop the head.
  - A simultaneous lsu_valid beat is pushed, so count is unchanged.
- LSU grant with FIFO empty: the incoming beat bypasses the FIFO; no push.
- lsu_valid with no LSU grant: push the beat.
- Push when full and no pop in the same cycle:
  - The beat is dropped and overflow is set.
  - overflow stays set until rst.
  - FIFO contents are unchanged.
- FIFO order is strict in-order. Read and write pointers wrap modulo LSU_FIFO_DEPTH. Full/empty is derived from the count.
- Output stage is registered, with 1-cycle latency from grant to rf_we.
  - rf_we = granted && (rd != 0).
  - A write to x0 is consumed but not written; rf_we=0.
  - rf_waddr and rf_wdata are loaded on every grant and hold otherwise.
  - rf_we is 0 on any cycle after a no-grant cycle.
- lsu_stall = (fifo_count >= LSU_FIFO_DEPTH-1), combinational from the registered count.
  - Load issue latency to lsu_valid must be <=1 outstanding beyond the stall point. This is an integration requirement.
- Reset mid-operation: FIFO contents are discarded, and any pending registered write is cancelled (rf_we=0 next cycle).
- Simultaneous ALU grant and LSU push: both happen. The ALU writes and the LSU beat is enqueued.

Decomposition:
- riscv_types already provides XLEN and rs_addr_t.
- Add to the shared package:
  - wb_src_t enum {WB_SRC_ALU, WB_SRC_LSU}, used for last_grant.
  - wb_entry_t packed struct {rs_addr_t rd; logic[XLEN-1:0] data}.
- One natural sub-module: wb_fifo, a parameterized synchronous FIFO of wb_entry_t.
  - Ports: push, pop, head, count, full, empty.
  - Pop-and-push on the same cycle is legal when full.
- Arbitration and the output register remain in wb_arbiter.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEAD_BEEF with no LSU activity -> alu_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- Same cycle: alu_valid (rd=3, 0x11) and lsu_valid (rd=4, 0x22) after reset -> ALU wins (last_grant=LSU at reset). The LSU beat is pushed and fifo_count=1. The following cycle, with alu_valid still high, the LSU head wins and alu_ready=0. Writes appear in order x3=0x11, then x4=0x22.
- lsu_valid for 4 consecutive cycles while alu_valid is held high -> grants alternate ALU/LSU. lsu_stall rises when fifo_count reaches 3. No overflow. All 4 loads are written in arrival order.
- ALU result to rd=0 -> alu_ready=1, rf_we stays 0, and round-robin still records an ALU grant.
- Fill the FIFO to 4 with LSU forced to lose, then one more lsu_valid with no pop -> overflow=1 and fifo_count stays 4. After draining, head data matches the first 4 beats. overflow clears only on rst.
- Assert rst with fifo_count=2 and a grant registered -> next cycle rf_we=0, fifo_count=0, overflow=0. A subsequent tie is granted to the ALU.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: data width, register address, result source and FIFO entry.
package wb_arbiter_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] rs_addr_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_t;

    typedef struct packed {
        rs_addr_t          rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // Writes to x0 are architecturally discarded.
    function automatic logic is_x0(rs_addr_t addr);
        return addr == 5'd0;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Result-source handshakes, register-file write port and FIFO status of the writeback arbiter.
interface wb_arbiter_if #(
    parameter int LSU_FIFO_DEPTH = 4
);
    import wb_arbiter_pkg::*;

    localparam int CNT_W = $clog2(LSU_FIFO_DEPTH) + 1;

    logic              alu_valid;
    logic              alu_ready;
    rs_addr_t          alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              lsu_valid;
    rs_addr_t          lsu_rd;
    logic [XLEN-1:0]   lsu_data;
    logic              lsu_stall;
    logic              rf_we;
    rs_addr_t          rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_stall, rf_we, rf_waddr, rf_wdata, fifo_count, overflow
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_stall, rf_we, rf_waddr, rf_wdata, fifo_count, overflow
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous in-order FIFO of writeback entries; simultaneous push and pop is legal when full.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        din,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    wb_entry_t          mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               full_s;
    logic               empty_s;
    logic               do_push_s;
    logic               do_pop_s;

    // Status flags come from the count; a full FIFO still accepts a push paired with a pop.
    always_comb begin
        full_s    = (count_r == CNT_W'(DEPTH));
        empty_s   = (count_r == {CNT_W{1'b0}});
        do_pop_s  = pop && !empty_s;
        do_push_s = push && (!full_s || do_pop_s);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; stale contents are never observed because count gates the head.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter between the ALU (backpressurable) and LSU (buffered) result paths,
// driving a registered register-file write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int LSU_FIFO_DEPTH = 4,
    localparam int CNT_W          = $clog2(LSU_FIFO_DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    wb_src_t            last_grant_r;
    logic               rf_we_r;
    rs_addr_t           rf_waddr_r;
    logic [XLEN-1:0]    rf_wdata_r;
    logic               overflow_r;

    wb_entry_t          fifo_head_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               fifo_pop_s;
    logic               fifo_push_s;

    wb_entry_t          lsu_beat_s;
    wb_entry_t          grant_entry_s;
    logic               l_present_s;
    logic               alu_ready_s;
    logic               grant_alu_s;
    logic               grant_lsu_s;
    logic               lsu_push_s;
    logic               drop_s;

    wb_fifo #(
        .DEPTH (LSU_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (lsu_beat_s),
        .head  (fifo_head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Arbitration: the ALU may proceed unless the LSU has something and had the last turn.
    always_comb begin
        lsu_beat_s    = '{rd: bus.lsu_rd, data: bus.lsu_data};
        l_present_s   = !fifo_empty_s || bus.lsu_valid;
        alu_ready_s   = !l_present_s || (last_grant_r == WB_SRC_LSU);
        grant_alu_s   = bus.alu_valid && alu_ready_s;
        grant_lsu_s   = l_present_s && !grant_alu_s;
        fifo_pop_s    = grant_lsu_s && !fifo_empty_s;
        // An incoming beat bypasses the FIFO only when it is itself the winner.
        lsu_push_s    = bus.lsu_valid && !(grant_lsu_s && fifo_empty_s);
        drop_s        = lsu_push_s && fifo_full_s && !fifo_pop_s;
        fifo_push_s   = lsu_push_s && !drop_s;
        if (grant_alu_s) begin
            grant_entry_s = '{rd: bus.alu_rd, data: bus.alu_data};
        end else if (!fifo_empty_s) begin
            grant_entry_s = fifo_head_s;
        end else begin
            grant_entry_s = lsu_beat_s;
        end
    end

    // Round-robin history, updated only on cycles that grant someone.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= WB_SRC_LSU;
        end else if (grant_alu_s) begin
            last_grant_r <= WB_SRC_ALU;
        end else if (grant_lsu_s) begin
            last_grant_r <= WB_SRC_LSU;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Registered write port: address/data hold between grants, enable is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= '0;
            rf_wdata_r <= '0;
        end else if (grant_alu_s || grant_lsu_s) begin
            rf_we_r    <= !is_x0(grant_entry_s.rd);
            rf_waddr_r <= grant_entry_s.rd;
            rf_wdata_r <= grant_entry_s.data;
        end else begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= rf_waddr_r;
            rf_wdata_r <= rf_wdata_r;
        end
    end

    // Sticky record of any LSU beat lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign bus.alu_ready  = alu_ready_s;
    assign bus.lsu_stall  = (fifo_count_s >= CNT_W'(LSU_FIFO_DEPTH - 1));
    assign bus.rf_we      = rf_we_r;
    assign bus.rf_waddr   = rf_waddr_r;
    assign bus.rf_wdata   = rf_wdata_r;
    assign bus.fifo_count = fifo_count_s;
    assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-based writeback reference model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.LSU_FIFO_DEPTH(DEPTH)) bus ();

    wb_arbiter #(.LSU_FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    wb_entry_t       q [$];
    bit              m_last_lsu;
    bit              m_we;
    logic [4:0]      m_waddr;
    logic [31:0]     m_wdata;
    bit              m_ovf;

    logic            obs_ready;
    logic            obs_stall;

    function automatic void model_reset();
        q.delete();
        m_last_lsu = 1'b1;
        m_we       = 1'b0;
        m_waddr    = 5'd0;
        m_wdata    = 32'd0;
        m_ovf      = 1'b0;
    endfunction

    // One clock: drive inputs, check combinational outputs, advance model, check registered outputs.
    task automatic step(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        bit l_pres, exp_ready, ga, gl, had_q;
        wb_entry_t g;
        @(negedge clk);
        rst           = r;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ld;
        #1;
        had_q     = (q.size() > 0);
        l_pres    = had_q || lv;
        exp_ready = !l_pres || m_last_lsu;
        obs_ready = bus.alu_ready;
        obs_stall = bus.lsu_stall;
        checks++;
        if (bus.alu_ready !== exp_ready) begin
            errors++;
            $display("FAIL alu_ready got=%b exp=%b t=%0t", bus.alu_ready, exp_ready, $time);
        end
        checks++;
        if (bus.lsu_stall !== (q.size() >= DEPTH - 1)) begin
            errors++;
            $display("FAIL lsu_stall got=%b exp=%b t=%0t", bus.lsu_stall, q.size() >= DEPTH - 1, $time);
        end
        if (r) begin
            model_reset();
        end else begin
            ga = av && exp_ready;
            gl = !ga && l_pres;
            g  = '{rd: ard, data: ad};
            if (ga) begin
                m_last_lsu = 1'b0;
            end else if (gl) begin
                m_last_lsu = 1'b1;
                if (had_q) g = q.pop_front();
                else       g = '{rd: lrd, data: ld};
            end
            if (lv && !(gl && !had_q)) begin
                if (q.size() < DEPTH) q.push_back('{rd: lrd, data: ld});
                else                  m_ovf = 1'b1;
            end
            if (ga || gl) begin
                m_we    = (g.rd != 5'd0);
                m_waddr = g.rd;
                m_wdata = g.data;
            end else begin
                m_we = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.rf_we !== m_we) begin
            errors++;
            $display("FAIL rf_we got=%b exp=%b t=%0t", bus.rf_we, m_we, $time);
        end
        checks++;
        if (bus.rf_waddr !== m_waddr || bus.rf_wdata !== m_wdata) begin
            errors++;
            $display("FAIL rf_write got=x%0d/%h exp=x%0d/%h t=%0t",
                     bus.rf_waddr, bus.rf_wdata, m_waddr, m_wdata, $time);
        end
        checks++;
        if (bus.fifo_count !== 3'(q.size())) begin
            errors++;
            $display("FAIL fifo_count got=%0d exp=%0d t=%0t", bus.fifo_count, q.size(), $time);
        end
        checks++;
        if (bus.overflow !== m_ovf) begin
            errors++;
            $display("FAIL overflow got=%b exp=%b t=%0t", bus.overflow, m_ovf, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rf we=%b addr=%0d data=%h exp=0/0/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.overflow !== 1'b0 || bus.lsu_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_status count=%0d ovf=%b stall=%b exp=0/0/0",
                     bus.fifo_count, bus.overflow, bus.lsu_stall);
        end
        do_reset();
    endtask

    task automatic test_alu_only();
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        checks++;
        if (obs_ready !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL alu_only ready=%b we=%b addr=%0d data=%h exp=1/1/5/deadbeef",
                     obs_ready, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        idle(1);
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd5) begin
            errors++;
            $display("FAIL alu_hold we=%b addr=%0d exp=0/5", bus.rf_we, bus.rf_waddr);
        end
    endtask

    task automatic test_tie();
        do_reset();
        step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        checks++;
        if (bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'h11 || bus.fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL tie_alu addr=%0d data=%h count=%0d exp=3/11/1", bus.rf_waddr, bus.rf_wdata, bus.fifo_count);
        end
        step(1'b0, 1'b1, 5'd7, 32'h33, 1'b0, 5'd0, 32'd0);
        checks++;
        if (obs_ready !== 1'b0 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'h22 || bus.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL tie_lsu ready=%b addr=%0d data=%h count=%0d exp=0/4/22/0",
                     obs_ready, bus.rf_waddr, bus.rf_wdata, bus.fifo_count);
        end
        step(1'b0, 1'b1, 5'd7, 32'h33, 1'b0, 5'd0, 32'd0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [4:0] lsu_order [$];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 5'd20, 32'hA0 + i, 1'b1, 5'(10 + i), 32'hB0 + i);
            if (bus.rf_we && bus.rf_waddr != 5'd20) lsu_order.push_back(bus.rf_waddr);
        end
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            step(1'b0, 1'b1, 5'd20, 32'hC0, 1'b0, 5'd0, 32'd0);
            if (bus.rf_we && bus.rf_waddr != 5'd20) lsu_order.push_back(bus.rf_waddr);
        end
        checks++;
        if (lsu_order.size() != 4 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count loads=%0d ovf=%b exp=4/0", lsu_order.size(), bus.overflow);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (lsu_order[i] !== 5'(10 + i)) begin
                    errors++;
                    $display("FAIL b2b_order idx=%0d got=x%0d exp=x%0d", i, lsu_order[i], 10 + i);
                end
            end
        end
        idle(1);
    endtask

    task automatic test_x0();
        do_reset();
        step(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
        checks++;
        if (obs_ready !== 1'b1 || bus.rf_we !== 1'b0) begin
            errors++;
            $display("FAIL x0_write ready=%b we=%b exp=1/0", obs_ready, bus.rf_we);
        end
        step(1'b0, 1'b1, 5'd8, 32'h5555, 1'b1, 5'd9, 32'h6666);
        checks++;
        if (bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'h6666) begin
            errors++;
            $display("FAIL x0_rr addr=%0d data=%h exp=9/6666", bus.rf_waddr, bus.rf_wdata);
        end
        idle(3);
    endtask

    task automatic test_overflow();
        bit saw_stall = 1'b0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 5'd1, 32'h100 + i, 1'b1, 5'(16 + i), 32'h200 + i);
            if (obs_stall === 1'b1) saw_stall = 1'b1;
        end
        checks++;
        if (bus.overflow !== 1'b1 || bus.fifo_count !== 3'd4 || !saw_stall) begin
            errors++;
            $display("FAIL ovf_set ovf=%b count=%0d stall_seen=%b exp=1/4/1", bus.overflow, bus.fifo_count, saw_stall);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky count=%0d ovf=%b exp=0/1", bus.fifo_count, bus.overflow);
        end
        do_reset();
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got=%b exp=0", bus.overflow);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'd2, 32'h300 + i, 1'b1, 5'd6, 32'h400 + i);
        checks++;
        if (bus.fifo_count !== 3'd2 || bus.rf_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup count=%0d we=%b exp=2/1", bus.fifo_count, bus.rf_we);
        end
        step(1'b1, 1'b1, 5'd2, 32'h500, 1'b1, 5'd6, 32'h600);
        checks++;
        if (bus.rf_we !== 1'b0 || bus.fifo_count !== 3'd0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset we=%b count=%0d ovf=%b exp=0/0/0", bus.rf_we, bus.fifo_count, bus.overflow);
        end
        step(1'b0, 1'b1, 5'd12, 32'h700, 1'b1, 5'd13, 32'h800);
        checks++;
        if (bus.rf_waddr !== 5'd12 || bus.rf_wdata !== 32'h700) begin
            errors++;
            $display("FAIL mid_tie addr=%0d data=%h exp=12/700", bus.rf_waddr, bus.rf_wdata);
        end
        idle(3);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(63) == 0, $urandom_range(1) == 1, 5'($urandom_range(31)), $urandom,
                 $urandom_range(9) < 4, 5'($urandom_range(31)), $urandom);
        end
        idle(8);
    endtask

    initial begin
        bus.alu_valid = 1'b0;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'd0;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = 5'd0;
        bus.lsu_data  = 32'd0;
        test_reset();
        test_alu_only();
        test_tie();
        test_back_to_back();
        test_x0();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
